// File: rtl/vermi_prefetch_pkg.sv
// Shared core types: the machine word, the canonical no-op instruction and
// the {pc, instruction} pair carried through the fetch queue.
package Vermitypes_pkg;

  typedef logic [31:0] word_t;

  // addi x0, x0, 0: harmless filler shown by an empty or freshly reset queue
  localparam word_t WORD_NOP  = 32'h0000_0013;
  localparam word_t WORD_STEP = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t data;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_RESET = '{pc: '0, data: WORD_NOP};

  // Instruction fetches are always word aligned, so redirect targets drop bits [1:0]
  function automatic word_t alignWord(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/vermi_prefetch_if.sv
// Bundle of the instruction-bus request side and the Decode-facing output side
// of the prefetch queue. The master modport is the prefetcher's own view.
interface vermi_prefetch_if;
  import Vermitypes_pkg::*;

  logic  mem_valid;
  logic  mem_ready;
  word_t mem_address;
  word_t mem_lookahead;
  word_t mem_rdata;

  logic  flush;
  word_t flush_pc;

  logic  out_valid;
  logic  out_ready;
  word_t out_pc;
  word_t out_data;

  modport master (
    output mem_valid, mem_address, mem_lookahead, out_valid, out_pc, out_data,
    input  mem_ready, mem_rdata, flush, flush_pc, out_ready
  );

  modport slave (
    input  mem_valid, mem_address, mem_lookahead, out_valid, out_pc, out_data,
    output mem_ready, mem_rdata, flush, flush_pc, out_ready
  );

endinterface

// File: rtl/vermi_prefetch_fifo.sv
// Generic registered FIFO with wrap-around pointers, so DEPTH does not need
// to be a power of two. Clear empties the queue without touching storage.
module vermi_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic [63:0],
  parameter T RESET_VAL = '0,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output T                 head_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushOk;
  logic             popOk;

  // Step a pointer forward, wrapping from the last slot back to slot 0
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // A push into a full queue is only honoured when a pop frees a slot in the same cycle
  assign popOk  = pop_i && (count_q != '0);
  assign pushOk = push_i && ((count_q != CNT_W'(DEPTH)) || popOk);

  // Next pointers and occupancy; clear wins over any push or pop
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clear_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pushOk) begin
        wr_d = bump(wr_q);
      end
      if (popOk) begin
        rd_d = bump(rd_q);
      end
      case ({pushOk, popOk})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; reset to a known filler so the head is defined before any write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (pushOk && !clear_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/vermi_prefetch.sv
// Instruction prefetch queue between the instruction bus and Decode. Keeps
// fetching while Decode stalls, redirects on flush, and can optionally hand a
// bus response straight to Decode when nothing is queued ahead of it.
module vermi_prefetch
  import Vermitypes_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter bit          BYPASS   = 1'b0,
  parameter word_t       RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  vermi_prefetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  word_t            pc_q, pc_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     pushEntry;
  word_t            flushTarget;
  logic             queueEmpty;
  logic             queueFull;
  logic             reqValid;
  logic             bypassSel;
  logic             outValid;
  logic             pushFire;
  logic             popFire;
  logic             fifoPush;
  logic             fifoPop;

  assign flushTarget = alignWord(bus.flush_pc);
  assign queueEmpty  = (count == '0);
  assign queueFull   = (count == CNT_W'(DEPTH));

  // A request is only raised when there is a slot for its answer; the reset
  // term drops it the moment reset is applied rather than at the next edge
  assign reqValid  = reset && !queueFull;
  assign bypassSel = BYPASS && queueEmpty && reqValid;
  assign outValid  = !bus.flush && (!queueEmpty || (bypassSel && bus.mem_ready));

  // A completing handshake is discarded when a redirect arrives in the same cycle
  assign pushFire  = reqValid && bus.mem_ready && !bus.flush;
  assign popFire   = outValid && bus.out_ready;

  // A bypassed word consumed by Decode right away never needs a queue slot
  assign fifoPush  = pushFire && !(bypassSel && popFire);
  assign fifoPop   = popFire && !queueEmpty;
  assign pushEntry = '{pc: pc_q, data: bus.mem_rdata};

  // Bus request and Decode-facing outputs, with the bypass path when the queue is empty
  always_comb begin
    bus.mem_valid     = reqValid;
    bus.mem_address   = pc_q;
    bus.mem_lookahead = bus.flush ? flushTarget : (pc_q + WORD_STEP);
    bus.out_valid     = outValid;
    bus.out_pc        = head.pc;
    bus.out_data      = head.data;
    if (bypassSel) begin
      bus.out_pc   = pc_q;
      bus.out_data = bus.mem_rdata;
    end
  end

  // Next fetch address: a redirect overrides normal sequential advance
  always_comb begin
    pc_d = pc_q;
    if (bus.flush) begin
      pc_d = flushTarget;
    end else if (pushFire) begin
      pc_d = pc_q + WORD_STEP;
    end
  end

  // Fetch address register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  vermi_fifo #(
    .DEPTH     (DEPTH),
    .T         (fetch_entry_t),
    .RESET_VAL (ENTRY_RESET)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .data_i  (pushEntry),
    .pop_i   (fifoPop),
    .clear_i (bus.flush),
    .count_o (count),
    .head_o  (head)
  );

endmodule

// File: tb/tb_vermi_prefetch.sv
// Bench for vermi_prefetch: two instances (queued and bypass flavours) share one
// directed stimulus stream; a queue-based reference model is compared on every
// falling edge, and literal expectations pin key points of the sequence.
module tb_vermi_prefetch;
  import Vermitypes_pkg::*;

  localparam int unsigned DEPTH_A    = 3;
  localparam bit          BYPASS_A   = 1'b0;
  localparam word_t       RESET_PC_A = 32'h0000_0000;
  localparam int unsigned DEPTH_B    = 2;
  localparam bit          BYPASS_B   = 1'b1;
  localparam word_t       RESET_PC_B = 32'h0000_0040;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  memReady = 1'b0;
  logic  flush = 1'b0;
  word_t flushPc = '0;
  logic  outReady = 1'b0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic  mv;
    word_t ma;
    word_t ml;
    logic  ov;
    word_t op;
    word_t od;
  } obs_t;

  // Reference model state, one slot per instance
  int unsigned  mDepth   [2] = '{DEPTH_A, DEPTH_B};
  bit           mBypass  [2] = '{BYPASS_A, BYPASS_B};
  word_t        mResetPc [2] = '{RESET_PC_A, RESET_PC_B};
  word_t        mPc      [2];
  fetch_entry_t mQ       [2][$];

  vermi_prefetch_if busA ();
  vermi_prefetch_if busB ();

  // Memory content: each word is derived from its own address
  function automatic word_t memWord(input word_t addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  assign busA.mem_ready = memReady;
  assign busA.flush     = flush;
  assign busA.flush_pc  = flushPc;
  assign busA.out_ready = outReady;
  assign busA.mem_rdata = memWord(busA.mem_address);
  assign busB.mem_ready = memReady;
  assign busB.flush     = flush;
  assign busB.flush_pc  = flushPc;
  assign busB.out_ready = outReady;
  assign busB.mem_rdata = memWord(busB.mem_address);

  vermi_prefetch #(.DEPTH(DEPTH_A), .BYPASS(BYPASS_A), .RESET_PC(RESET_PC_A)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  vermi_prefetch #(.DEPTH(DEPTH_B), .BYPASS(BYPASS_B), .RESET_PC(RESET_PC_B)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic fl,
                               input word_t fpc, input logic ordy);
    @(posedge clk);
    #1;
    reset    = rst;
    memReady = rdy;
    flush    = fl;
    flushPc  = fpc;
    outReady = ordy;
  endtask

  // Compare one instance against the model, then advance the model across the coming edge
  task automatic modelCompare(input int d, input obs_t o);
    string        tag;
    logic         expMv;
    logic         expOv;
    logic         emptyBefore;
    logic         hs;
    logic         pop;
    fetch_entry_t expHead;
    tag = (d == 0) ? "A" : "B";
    if (!reset) begin
      checkOutput({tag, ".rst.mem_valid"}, word_t'(o.mv), 32'd0);
      checkOutput({tag, ".rst.mem_address"}, o.ma, mResetPc[d]);
      checkOutput({tag, ".rst.mem_lookahead"}, o.ml,
                  flush ? alignWord(flushPc) : mResetPc[d] + 32'd4);
      checkOutput({tag, ".rst.out_valid"}, word_t'(o.ov), 32'd0);
      checkOutput({tag, ".rst.out_pc"}, o.op, 32'd0);
      checkOutput({tag, ".rst.out_data"}, o.od, WORD_NOP);
      mPc[d] = mResetPc[d];
      mQ[d].delete();
    end else begin
      emptyBefore = (mQ[d].size() == 0);
      expMv = (mQ[d].size() < mDepth[d]);
      expOv = !flush && (!emptyBefore || (mBypass[d] && expMv && memReady));
      checkOutput({tag, ".mem_valid"}, word_t'(o.mv), word_t'(expMv));
      checkOutput({tag, ".mem_address"}, o.ma, mPc[d]);
      checkOutput({tag, ".mem_lookahead"}, o.ml, flush ? alignWord(flushPc) : mPc[d] + 32'd4);
      checkOutput({tag, ".out_valid"}, word_t'(o.ov), word_t'(expOv));
      if (expOv) begin
        expHead = emptyBefore ? '{pc: mPc[d], data: memWord(mPc[d])} : mQ[d][0];
        checkOutput({tag, ".out_pc"}, o.op, expHead.pc);
        checkOutput({tag, ".out_data"}, o.od, expHead.data);
      end
      if (flush) begin
        mQ[d].delete();
        mPc[d] = alignWord(flushPc);
      end else begin
        hs  = expMv && memReady;
        pop = expOv && outReady;
        if (pop && !emptyBefore) begin
          void'(mQ[d].pop_front());
        end
        if (hs && !(emptyBefore && pop)) begin
          mQ[d].push_back('{pc: mPc[d], data: memWord(mPc[d])});
        end
        if (hs) begin
          mPc[d] = mPc[d] + 32'd4;
        end
      end
    end
  endtask

  // Every falling edge: sample both instances and check them against the model
  always @(negedge clk) begin
    obs_t oA;
    obs_t oB;
    oA = '{mv: busA.mem_valid, ma: busA.mem_address, ml: busA.mem_lookahead,
           ov: busA.out_valid, op: busA.out_pc, od: busA.out_data};
    oB = '{mv: busB.mem_valid, ma: busB.mem_address, ml: busB.mem_lookahead,
           ov: busB.out_valid, op: busB.out_pc, od: busB.out_data};
    modelCompare(0, oA);
    modelCompare(1, oB);
  end

  // Directed sequence with literal expectations
  initial begin
    int          hsCount;
    logic [19:0] rdyPat;
    logic [19:0] ordyPat;
    rdyPat  = 20'b1011_1101_1110_1011_0111;
    ordyPat = 20'b0110_1011_0011_1101_1010;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("A.reset.mem_valid", word_t'(busA.mem_valid), 32'd0);
    checkOutput("A.reset.mem_address", busA.mem_address, 32'h0);
    checkOutput("A.reset.mem_lookahead", busA.mem_lookahead, 32'h4);
    checkOutput("A.reset.out_data", busA.out_data, 32'h0000_0013);
    checkOutput("B.reset.mem_address", busB.mem_address, 32'h40);

    // Zero-wait streaming: A shows 0,4,8,12 from the second cycle, B bypasses at once
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.stream.first_mem_valid", word_t'(busA.mem_valid), 32'd1);
    checkOutput("A.stream.cycle1_out_valid", word_t'(busA.out_valid), 32'd0);
    checkOutput("B.bypass.out_valid", word_t'(busB.out_valid), 32'd1);
    checkOutput("B.bypass.out_pc", busB.out_pc, 32'h40);
    checkOutput("B.bypass.out_data", busB.out_data, 32'h0040_FFBF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("A.stream.out_valid", word_t'(busA.out_valid), 32'd1);
      checkOutput("A.stream.out_pc", busA.out_pc, word_t'(4 * i));
      checkOutput("B.bypass.next_out_pc", busB.out_pc, word_t'(32'h44 + 4 * i));
    end

    // Redirect to 0 with Decode stalled, then fill until full
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    #1;
    checkOutput("A.flush.out_valid", word_t'(busA.out_valid), 32'd0);
    checkOutput("A.flush.lookahead", busA.mem_lookahead, 32'h0);
    hsCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      if (busA.mem_valid && memReady) begin
        hsCount++;
      end
    end
    checkOutput("A.full.handshakes", word_t'(hsCount), 32'd3);
    checkOutput("A.full.mem_valid", word_t'(busA.mem_valid), 32'd0);
    checkOutput("A.full.mem_address", busA.mem_address, 32'd12);
    checkOutput("B.full.mem_address", busB.mem_address, 32'd8);

    // Drain: request returns one cycle after the first pop
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.drain1.out_pc", busA.out_pc, 32'd0);
    checkOutput("A.drain1.mem_valid", word_t'(busA.mem_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.drain2.out_pc", busA.out_pc, 32'd4);
    checkOutput("A.drain2.mem_valid", word_t'(busA.mem_valid), 32'd1);
    checkOutput("A.drain2.mem_address", busA.mem_address, 32'd12);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.drain3.out_pc", busA.out_pc, 32'd8);

    // Flush to 0x100 with two entries queued and a handshake completing
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
    #1;
    checkOutput("A.redir.out_valid", word_t'(busA.out_valid), 32'd0);
    checkOutput("A.redir.mem_address", busA.mem_address, 32'd20);
    checkOutput("A.redir.lookahead", busA.mem_lookahead, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.redir.new_address", busA.mem_address, 32'h100);
    checkOutput("A.redir.empty_out_valid", word_t'(busA.out_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.redir.out_pc", busA.out_pc, 32'h100);
    checkOutput("A.redir.out_data", busA.out_data, 32'h0100_FEFF);

    // Misaligned redirect, then a fixed irregular push/pop pattern
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h202, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("A.align.mem_address", busA.mem_address, 32'h200);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, rdyPat[i], 1'b0, 32'h0, ordyPat[i]);
    end

    // Reset pulled mid-stream with two entries queued
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("A.midrst.pre_out_valid", word_t'(busA.out_valid), 32'd1);
    checkOutput("A.midrst.pre_mem_valid", word_t'(busA.mem_valid), 32'd1);
    checkOutput("A.midrst.pre_out_pc", busA.out_pc, 32'h300);
    #1 reset = 1'b0;
    #1;
    checkOutput("A.midrst.out_valid", word_t'(busA.out_valid), 32'd0);
    checkOutput("A.midrst.mem_valid", word_t'(busA.mem_valid), 32'd0);
    checkOutput("B.midrst.mem_valid", word_t'(busB.mem_valid), 32'd0);
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("A.restart.mem_address", busA.mem_address, 32'h0);
    checkOutput("A.restart.mem_valid", word_t'(busA.mem_valid), 32'd1);
    checkOutput("B.restart.mem_address", busB.mem_address, 32'h40);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
